alu_serial: RTL and testbench
=============================

# alu_serial

Bit-serial 32-bit ALU sequencer. It sits directly upstream of the 1-bit ALU slice and drives it. On `start` it captures two operands and a 4-bit ALU control code, then feeds one bit pair per cycle (LSB first) into a single 1-bit slice. It collects the result bits and carry chain, and presents the full-width result with zero/carry/overflow flags to the datapath.

## Interface
- `WIDTH`, 32: operand/result width, ≥ 2.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `src1`  in  WIDTH  operand A; captured on accepted `start`.
- `src2`  in  WIDTH  operand B; captured on accepted `start`.
- `alu_ctrl`  in  4  operation code; captured on accepted `start`.
- `busy`  out  1  high from the cycle after acceptance until `done`, inclusive.
- `done`  out  1  single-cycle pulse; result and flags valid from this cycle.
- `result`  out  WIDTH  registered result; held until next accepted `start`.
- `zero`  out  1  `result == 0`.
- `cout`  out  1  carry out of MSB slice.
- `overflow`  out  1  signed overflow; only defined for ADD/SUB, forced 0 otherwise.

## Operation
- Decode of `alu_ctrl` to {A_invert, B_invert, operation[1:0], cin}:
  - 0000 AND: {0,0,00,0}
  - 0001 OR: {0,0,01,0}
  - 0010 ADD: {0,0,10,0}
  - 0110 SUB: {0,1,10,1}
  - 0111 SLT: {0,1,10,1}
  - 1100 NOR: {1,1,00,0}
- Any other code runs as AND with both operands treated as 0. Result is 0, `zero`=1, and `done` still pulses.
- The slice `less` input is tied 0. SLT runs as SUB, then the final result is replaced by {0…0, set}, where set = sum[MSB] XOR overflow.
- States:
  - IDLE: `start`=1 captures operands/control, clears the bit counter, loads carry ← cin, and moves to RUN.
  - RUN: each cycle the slice gets src1[idx], src2[idx] and the carry register. The slice result is shifted into `result` from the MSB side (shift right), and carry ← slice cout.
    - On idx = WIDTH-2, the carry-in is saved as c_msb_in.
    - After idx = WIDTH-1, the block moves to DONE.
  - DONE: the final result and flags are written, `done`=1 for one cycle, then the block returns to IDLE.
- Flags:
  - `cout` is the carry out of the last slice.
  - `overflow` = c_msb_in XOR `cout`.
  - `zero` is computed on the final (post-SLT) result.
- `start` while not in IDLE is ignored. No queuing and no error.
- Bit counter width is $clog2(WIDTH). There is no wrap past WIDTH-1.

## Timing
- Reset (async assert, sync deassert handled upstream): state=IDLE. `busy`, `done`, `result`, `zero`, `cout`, `overflow` are all 0. Reset mid-RUN discards partial results.
- `start` accepted at edge 0 → `busy`=1 from edge 0 → RUN covers edges 1..WIDTH → `done`=1 and outputs updated at edge WIDTH+1 → `busy`=0 at edge WIDTH+2.
- Latency is WIDTH+1 cycles (33 for the default). Throughput is one operation per WIDTH+2 cycles.
- `start` high in the same cycle `done` is high is ignored, because the block is not in IDLE. The next acceptance is possible from edge WIDTH+2.
- `result` and the flags change only in DONE or on reset. Intermediate shifting happens in an internal register.

## Structure
- Shared package `alu_pkg`:
  - ALU control code constants (AND/OR/ADD/SUB/SLT/NOR).
  - slice operation encodings (00 AND, 01 OR, 10 ADD, 11 LESS).
  - state enum {IDLE, RUN, DONE}.
- One sub-module: a single instance of the existing 1-bit slice `alu_top`, driven combinationally from the captured registers.
- Everything else is in one always_ff block plus a decode always_comb.

## Test plan
- ADD 7 + 5 → `result`=12, `cout`=0, `overflow`=0, `zero`=0; `done` exactly 33 cycles after `start`.
- SUB 0x80000000 − 1 → `result`=0x7FFFFFFF, `overflow`=1, `cout`=1.
- SLT src1=0xFFFFFFFF (−1), src2=1 → `result`=1. SLT with 0x7FFFFFFF vs 0x80000000 → `result`=0, exercising the overflow-corrected set.
- NOR 0,0 → 0xFFFFFFFF, `zero`=0. AND 0xF0F0F0F0, 0x0F0F0F0F → 0, `zero`=1. Code 1111 → `result`=0, `zero`=1, `done` pulses.
- `start` re-asserted with new operands at cycles 5 and 33 during an ADD → the first result is unaffected, and the second request is ignored (not in IDLE).
- `rst` pulsed at cycle 10 of a SUB → all outputs 0 immediately, `busy`=0; the next `start` completes correctly with no residue from the aborted operation.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the bit-serial ALU sequencer and its
//                1-bit slice: ALU control codes, slice operation encodings,
//                sequencer states and the control-code decoder.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int C_WIDTH_DEFAULT = 32;

   // External ALU control codes
   localparam logic [3:0] C_CTRL_AND = 4'b0000;
   localparam logic [3:0] C_CTRL_OR  = 4'b0001;
   localparam logic [3:0] C_CTRL_ADD = 4'b0010;
   localparam logic [3:0] C_CTRL_SUB = 4'b0110;
   localparam logic [3:0] C_CTRL_SLT = 4'b0111;
   localparam logic [3:0] C_CTRL_NOR = 4'b1100;

   // Result multiplexer select inside the 1-bit slice
   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_ADD  = 2'b10,
      OP_LESS = 2'b11
   } slice_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Decoded control word held for the whole serial operation
   typedef struct packed {
      logic      a_inv;
      logic      b_inv;
      slice_op_t op;
      logic      cin;
      logic      slt;    // replace result by the signed-less-than bit
      logic      arith;  // overflow flag is meaningful (ADD/SUB)
      logic      valid;  // unknown codes run as AND on zero operands
   } ctl_t;

   function automatic ctl_t decode_ctrl(input logic [3:0] code);
      ctl_t c;
      c       = '0;
      c.op    = OP_AND;
      c.valid = 1'b1;
      case (code)
         C_CTRL_AND: c.op = OP_AND;
         C_CTRL_OR:  c.op = OP_OR;
         C_CTRL_ADD: begin
            c.op    = OP_ADD;
            c.arith = 1'b1;
         end
         C_CTRL_SUB: begin
            c.b_inv = 1'b1;
            c.op    = OP_ADD;
            c.cin   = 1'b1;
            c.arith = 1'b1;
         end
         C_CTRL_SLT: begin
            c.b_inv = 1'b1;
            c.op    = OP_ADD;
            c.cin   = 1'b1;
            c.slt   = 1'b1;
         end
         C_CTRL_NOR: begin
            c.a_inv = 1'b1;
            c.b_inv = 1'b1;
            c.op    = OP_AND;
         end
         default: c.valid = 1'b0;
      endcase
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_serial_if
//  Description : Request/result bundle between the datapath and the
//                bit-serial ALU sequencer.
//  Signals     : start, src1, src2, alu_ctrl   (datapath -> sequencer)
//                busy, done, result, zero, cout, overflow (sequencer -> datapath)
//  Modports    : master (datapath side), slave (sequencer side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_serial_if
   import alu_pkg::*;
#(
   parameter int WIDTH = C_WIDTH_DEFAULT
);
   logic             start;
   logic [WIDTH-1:0] src1;
   logic [WIDTH-1:0] src2;
   logic [3:0]       alu_ctrl;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             cout;
   logic             overflow;

   modport master (
      output start, src1, src2, alu_ctrl,
      input  busy, done, result, zero, cout, overflow
   );

   modport slave (
      input  start, src1, src2, alu_ctrl,
      output busy, done, result, zero, cout, overflow
   );
endinterface
`default_nettype wire

// File: rtl/alu_top.sv
`default_nettype none
// ============================================================================
//  Module      : alu_top
//  Description : Combinational 1-bit ALU slice (AND / OR / full-adder / less)
//                with per-operand inversion.
//  Ports       : a_i, b_i           operand bits
//                a_invert_i, b_invert_i  operand inversion controls
//                cin_i              carry in
//                less_i             value selected by OP_LESS
//                op_i               result select
//                result_o, cout_o   slice result and carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_top
   import alu_pkg::*;
(
   input  wire logic      a_i,
   input  wire logic      b_i,
   input  wire logic      a_invert_i,
   input  wire logic      b_invert_i,
   input  wire logic      cin_i,
   input  wire logic      less_i,
   input  wire slice_op_t op_i,
   output      logic      result_o,
   output      logic      cout_o
);
   logic w_a;
   logic w_b;
   logic w_sum;

   assign w_a    = a_i ^ a_invert_i;
   assign w_b    = b_i ^ b_invert_i;
   assign w_sum  = w_a ^ w_b ^ cin_i;
   assign cout_o = (w_a & w_b) | (w_a & cin_i) | (w_b & cin_i);

   always_comb begin
      result_o = 1'b0;
      case (op_i)
         OP_AND:  result_o = w_a & w_b;
         OP_OR:   result_o = w_a | w_b;
         OP_ADD:  result_o = w_sum;
         OP_LESS: result_o = less_i;
         default: result_o = 1'b0;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/alu_serial.sv
`default_nettype none
// ============================================================================
//  Module      : alu_serial
//  Description : Bit-serial ALU sequencer. Captures two operands and a control
//                code on start, walks them LSB first through one alu_top
//                slice, then publishes the result with zero/carry/overflow.
//  Ports       : clk   system clock (rising edge)
//                rst   asynchronous active-high reset
//                bus   alu_serial_if.slave: start/src1/src2/alu_ctrl in,
//                      busy/done/result/zero/cout/overflow out
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_serial
   import alu_pkg::*;
#(
   parameter int WIDTH = C_WIDTH_DEFAULT
)(
   input  wire logic clk,
   input  wire logic rst,
   alu_serial_if.slave bus
);
   localparam int               IDX_W     = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] C_IDX_MSB = IDX_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q;
   logic [WIDTH-1:0] a_q, b_q;
   ctl_t             ctl_q;
   logic             carry_q;
   logic             c_msb_q;   // carry into the MSB slice
   logic [WIDTH-1:0] shift_q;   // result bits collected MSB-side first
   logic [WIDTH-1:0] result_q;
   logic             zero_q, cout_q, ovf_q, done_q;

   ctl_t             w_dec;
   logic             w_accept;
   logic             w_a_bit, w_b_bit;
   logic             w_slice_res, w_slice_cout;
   logic             w_ovf, w_set;
   logic [WIDTH-1:0] w_final;

   // The done cycle still counts as busy, so a start coinciding with done
   // is not taken even though the state register is already back in IDLE.
   assign w_accept = (state_q == S_IDLE) && !done_q && bus.start;

   always_comb begin
      w_dec = decode_ctrl(bus.alu_ctrl);
   end

   // Unknown codes run on zero operands
   assign w_a_bit = a_q[idx_q] & ctl_q.valid;
   assign w_b_bit = b_q[idx_q] & ctl_q.valid;

   alu_top u_slice (
      .a_i        (w_a_bit),
      .b_i        (w_b_bit),
      .a_invert_i (ctl_q.a_inv),
      .b_invert_i (ctl_q.b_inv),
      .cin_i      (carry_q),
      .less_i     (1'b0),
      .op_i       (ctl_q.op),
      .result_o   (w_slice_res),
      .cout_o     (w_slice_cout)
   );

   // Final flags, evaluated in DONE once carry_q holds the MSB carry out
   assign w_ovf   = c_msb_q ^ carry_q;
   assign w_set   = shift_q[WIDTH-1] ^ w_ovf;
   assign w_final = ctl_q.slt ? {{(WIDTH-1){1'b0}}, w_set} : shift_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (w_accept) state_d = S_RUN;
         S_RUN:   if (idx_q == C_IDX_MSB) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         ctl_q    <= '0;
         carry_q  <= 1'b0;
         c_msb_q  <= 1'b0;
         shift_q  <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= (state_q == S_DONE);
         case (state_q)
            S_IDLE: begin
               if (w_accept) begin
                  a_q     <= bus.src1;
                  b_q     <= bus.src2;
                  ctl_q   <= w_dec;
                  carry_q <= w_dec.cin;
                  idx_q   <= '0;
                  c_msb_q <= 1'b0;
               end
            end
            S_RUN: begin
               shift_q <= {w_slice_res, shift_q[WIDTH-1:1]};
               carry_q <= w_slice_cout;
               // Carry out of slice WIDTH-2 is the carry into the MSB slice
               if (idx_q == C_IDX_MSB - 1'b1) begin
                  c_msb_q <= w_slice_cout;
               end
               if (idx_q != C_IDX_MSB) begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            S_DONE: begin
               result_q <= w_final;
               zero_q   <= (w_final == '0);
               cout_q   <= carry_q;
               ovf_q    <= ctl_q.arith & w_ovf;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy     = (state_q != S_IDLE) || done_q;
   assign bus.done     = done_q;
   assign bus.result   = result_q;
   assign bus.zero     = zero_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_serial
//  Description : Self-checking bench for alu_serial. Expected results come
//                from a word-level arithmetic model pushed to a scoreboard
//                when a request is issued and popped when done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial;
   import alu_pkg::*;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] res;
      logic         z;
      logic         c;
      logic         v;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   alu_serial_if #(.WIDTH(W)) bus ();

   alu_serial #(.WIDTH(W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t       e;
      logic [W:0] s;
      e = '0;
      s = '0;
      case (ctrl)
         C_CTRL_AND: begin e.res = a & b; s = {1'b0, a} + {1'b0, b}; e.c = s[W]; end
         C_CTRL_OR:  begin e.res = a | b; s = {1'b0, a} + {1'b0, b}; e.c = s[W]; end
         C_CTRL_ADD: begin
            s     = {1'b0, a} + {1'b0, b};
            e.res = s[W-1:0];
            e.c   = s[W];
            e.v   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
         end
         C_CTRL_SUB: begin
            s     = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            e.res = s[W-1:0];
            e.c   = s[W];
            e.v   = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
         end
         C_CTRL_SLT: begin
            s     = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            e.res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            e.c   = s[W];
         end
         C_CTRL_NOR: begin e.res = ~(a | b); s = {1'b0, ~a} + {1'b0, ~b}; e.c = s[W]; end
         default: e = '0;
      endcase
      e.z = (e.res == '0);
      return e;
   endfunction

   // Drive a request; acceptance happens on the following rising edge.
   task automatic issue(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.src1     = a;
      bus.src2     = b;
      bus.alu_ctrl = ctrl;
      if (push) sb_q.push_back(model(ctrl, a, b));
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("busy_after_accept", W'(bus.busy), W'(1));
   endtask

   // Wait for done (bounded), compare against the scoreboard. With poke set,
   // new requests are thrown at the busy DUT mid-run and in the done cycle.
   task automatic wait_done(input string tag, input bit poke, output int lat);
      exp_t e;
      lat = 0;
      while (lat < 100) begin
         @(posedge clk);
         lat++;
         #1;
         bus.start = poke && (lat == 5);
         if (poke && lat == 5) begin
            bus.src1     = 32'hFFFF_FFFF;
            bus.src2     = 32'h0000_0001;
            bus.alu_ctrl = C_CTRL_SUB;
         end
         if (bus.done) break;
      end
      if (bus.done !== 1'b1) begin
         chk({tag, "_timeout"}, W'(bus.done), W'(1));
         return;
      end
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, W'(sb_q.size()), W'(1));
         return;
      end
      e = sb_q.pop_front();
      chk({tag, "_result"},   bus.result,          e.res);
      chk({tag, "_zero"},     W'(bus.zero),        W'(e.z));
      chk({tag, "_cout"},     W'(bus.cout),        W'(e.c));
      chk({tag, "_overflow"}, W'(bus.overflow),    W'(e.v));
      chk({tag, "_busy_done"}, W'(bus.busy),       W'(1));
      if (poke) bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk({tag, "_done_pulse"}, W'(bus.done), W'(0));
      chk({tag, "_busy_end"},   W'(bus.busy), W'(0));
      if (poke) begin
         chk({tag, "_hold"}, bus.result, e.res);
         @(posedge clk);
         #1;
         chk({tag, "_ignored"}, W'(bus.busy), W'(0));
      end
   endtask

   task automatic run(input string tag, input logic [3:0] ctrl, input logic [W-1:0] a,
                      input logic [W-1:0] b, input bit poke);
      int lat;
      issue(ctrl, a, b, 1'b1);
      wait_done(tag, poke, lat);
   endtask

   initial begin
      int lat;
      logic [3:0] codes [7];
      codes = '{C_CTRL_AND, C_CTRL_OR, C_CTRL_ADD, C_CTRL_SUB, C_CTRL_SLT, C_CTRL_NOR, 4'b0101};

      bus.start    = 1'b0;
      bus.src1     = '0;
      bus.src2     = '0;
      bus.alu_ctrl = '0;
      rst          = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy",     W'(bus.busy),     W'(0));
      chk("rst_done",     W'(bus.done),     W'(0));
      chk("rst_result",   bus.result,       W'(0));
      chk("rst_zero",     W'(bus.zero),     W'(0));
      chk("rst_cout",     W'(bus.cout),     W'(0));
      chk("rst_overflow", W'(bus.overflow), W'(0));
      @(negedge clk);
      rst = 1'b0;

      // ADD with latency measurement from the accepting edge
      issue(C_CTRL_ADD, 32'd7, 32'd5, 1'b1);
      wait_done("add_7_5", 1'b0, lat);
      chk("add_latency", W'(lat), W'(33));

      run("sub_min_1",  C_CTRL_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0);
      run("slt_neg",    C_CTRL_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      run("slt_ovf",    C_CTRL_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
      run("nor_0_0",    C_CTRL_NOR, 32'h0000_0000, 32'h0000_0000, 1'b0);
      run("and_zero",   C_CTRL_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0);
      run("bad_code",   4'b1111,    32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      run("or_mix",     C_CTRL_OR,  32'hA000_0005, 32'h0500_00A0, 1'b0);

      // Requests at cycle 5 and in the done cycle must both be ignored
      run("add_poke",   C_CTRL_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);

      // Reset ten cycles into a SUB
      issue(C_CTRL_SUB, 32'hDEAD_BEEF, 32'h0000_1111, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_busy",     W'(bus.busy),     W'(0));
      chk("abort_done",     W'(bus.done),     W'(0));
      chk("abort_result",   bus.result,       W'(0));
      chk("abort_cout",     W'(bus.cout),     W'(0));
      chk("abort_overflow", W'(bus.overflow), W'(0));
      chk("abort_zero",     W'(bus.zero),     W'(0));
      @(negedge clk);
      rst = 1'b0;
      run("sub_after_rst", C_CTRL_SUB, 32'd100, 32'd200, 1'b0);

      for (int i = 0; i < 6; i++) begin
         run("rand_op", codes[$urandom_range(0, 6)], 32'($urandom), 32'($urandom), 1'b0);
      end

      chk("sb_drained", W'(sb_q.size()), W'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
